// File: rtl/pe_arr_result_drain.sv
// Snapshots the PE array result bus on capture and streams it out row-major over valid/ready.
// Optional DRAIN_SAT8_EN: each beat is the element arithmetically shifted by SHIFT and saturated to int8.
module pe_arr_result_drain #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned SHIFT = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 capture,
    input  logic [0:ROWS*COLS*ACC_W-1]           res_port,
    output logic                                 out_valid,
    input  logic                                 out_ready,
`ifdef DRAIN_SAT8_EN
    output logic [7:0]                           out_data,
`else
    output logic [ACC_W-1:0]                     out_data,
`endif
    output logic [((ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1)-1:0] out_idx,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overrun
);

    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {StIdle, StDrain} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             load;
    logic             hs;
    logic             final_beat;
    logic [ACC_W-1:0] snap_q [N];
    logic [ACC_W-1:0] cur;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        overrun_d  = 1'b0;
        load       = 1'b0;
        hs         = (state_q == StDrain) && out_ready;
        final_beat = (idx_q == IDX_W'(N - 1));
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (hs) begin
                    if (final_beat) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        // A capture on the final handshake chains straight into the next drain.
                        if (capture) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                if (capture && !(hs && final_beat)) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Buffer carries no reset; contents are only observed while draining.
    always_ff @(posedge clk) begin
        if (load && !rst) begin
            for (int i = 0; i < N; i++) begin
                snap_q[i] <= res_port[ACC_W*i +: ACC_W];
            end
        end
    end

    assign cur = snap_q[idx_q];

`ifdef DRAIN_SAT8_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = 127;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -128;

    logic signed [ACC_W-1:0] shifted;
    logic        [7:0]       sat;

    always_comb begin
        shifted = $signed(cur) >>> SHIFT;
        if (shifted > SAT_MAX) begin
            sat = 8'h7f;
        end else if (shifted < SAT_MIN) begin
            sat = 8'h80;
        end else begin
            sat = shifted[7:0];
        end
    end
`endif

    always_comb begin
        out_valid = (state_q == StDrain);
        busy      = out_valid;
        out_idx   = out_valid ? idx_q : '0;
        out_last  = out_valid && final_beat;
        done      = done_q;
        overrun   = overrun_q;
`ifdef DRAIN_SAT8_EN
        out_data  = out_valid ? sat : '0;
`else
        out_data  = out_valid ? cur : '0;
`endif
    end

endmodule
